// File: rtl/kypd_scan_encoder_pkg.sv
// -----------------------------------------------------------------------------
// kypd_pkg
// Shared definitions for the 4x4 keypad scan encoder:
//   - NO_KEY      : 5-bit "no key pressed" sentinel (MSB set, never a key index)
//   - KEY_0..KEY_F: ASCII codes emitted on KBCODE
//   - key_to_ascii: key index {row[1:0], col[1:0]} -> ASCII code
//   - kypd_state_e: press FSM states
// -----------------------------------------------------------------------------
package kypd_pkg;

    // A valid key index is 4 bits; the extra MSB marks "nothing pressed".
    localparam logic [4:0] NO_KEY = 5'b1_0000;

    localparam logic [7:0] KEY_0 = 8'h30;
    localparam logic [7:0] KEY_1 = 8'h31;
    localparam logic [7:0] KEY_2 = 8'h32;
    localparam logic [7:0] KEY_3 = 8'h33;
    localparam logic [7:0] KEY_4 = 8'h34;
    localparam logic [7:0] KEY_5 = 8'h35;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h37;
    localparam logic [7:0] KEY_8 = 8'h38;
    localparam logic [7:0] KEY_9 = 8'h39;
    localparam logic [7:0] KEY_A = 8'h41;
    localparam logic [7:0] KEY_B = 8'h42;
    localparam logic [7:0] KEY_C = 8'h43;
    localparam logic [7:0] KEY_D = 8'h44;
    localparam logic [7:0] KEY_E = 8'h45;
    localparam logic [7:0] KEY_F = 8'h46;

    typedef enum logic [1:0] {
        ARMED = 2'b00,
        FIRE  = 2'b01,
        HELD  = 2'b10
    } kypd_state_e;

    // Key index is {row, col}; layout follows the physical keypad legend.
    function automatic logic [7:0] key_to_ascii(input logic [3:0] idx);
        logic [7:0] code;
        case (idx)
            4'd0:    code = KEY_1;
            4'd1:    code = KEY_2;
            4'd2:    code = KEY_3;
            4'd3:    code = KEY_A;
            4'd4:    code = KEY_4;
            4'd5:    code = KEY_5;
            4'd6:    code = KEY_6;
            4'd7:    code = KEY_B;
            4'd8:    code = KEY_7;
            4'd9:    code = KEY_8;
            4'd10:   code = KEY_9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_0;
            4'd13:   code = KEY_F;
            4'd14:   code = KEY_E;
            4'd15:   code = KEY_D;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/kypd_scan_encoder_col_scan.sv
// -----------------------------------------------------------------------------
// kypd_col_scan
// Walks a single low column across the keypad, synchronizes the rows and
// reduces each full scan to one key index (lowest column, then lowest row).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   row_i[3:0] : raw keypad rows (pulled up, pressed = 0)
//   col_o[3:0] : registered column drive, one bit low
//   key_o[4:0] : result of the last complete scan (NO_KEY if none)
//   eos_o      : one-cycle pulse when key_o is refreshed (end of scan)
// -----------------------------------------------------------------------------
module kypd_col_scan
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [4:0] key_o,
    output logic       eos_o
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [3:0]       row_meta_q, row_meta_d;
    logic [3:0]       row_sync_q, row_sync_d;
    logic [DIV_W-1:0] div_cnt_q,  div_cnt_d;
    logic [1:0]       col_idx_q,  col_idx_d;
    logic [3:0]       col_q,      col_d;
    logic [4:0]       scan_key_q, scan_key_d;
    logic [4:0]       key_q,      key_d;
    logic             eos_q,      eos_d;
    logic             sample_s;
    logic [4:0]       col_hit_s;

    // Scan sequencing, per-column sampling and end-of-scan result capture.
    always_comb begin
        row_meta_d = row_i;
        row_sync_d = row_meta_q;
        div_cnt_d  = div_cnt_q;
        col_idx_d  = col_idx_q;
        scan_key_d = scan_key_q;
        key_d      = key_q;
        eos_d      = 1'b0;
        sample_s   = (div_cnt_q == DIV_LAST);

        // Lowest pressed row within the currently driven column.
        casez (row_sync_q)
            4'b???0: col_hit_s = {1'b0, 2'd0, col_idx_q};
            4'b??01: col_hit_s = {1'b0, 2'd1, col_idx_q};
            4'b?011: col_hit_s = {1'b0, 2'd2, col_idx_q};
            4'b0111: col_hit_s = {1'b0, 2'd3, col_idx_q};
            default: col_hit_s = NO_KEY;
        endcase

        // Sampling at the end of the dwell lets the synchronizer and the
        // keypad lines settle after the column switched.
        if (sample_s) begin
            div_cnt_d = {DIV_W{1'b0}};
            col_idx_d = col_idx_q + 2'd1;
            if (col_idx_q == 2'd0) begin
                scan_key_d = col_hit_s;
            end else if (scan_key_q == NO_KEY) begin
                scan_key_d = col_hit_s;
            end else begin
                scan_key_d = scan_key_q;
            end
            if (col_idx_q == 2'd3) begin
                key_d = scan_key_d;
                eos_d = 1'b1;
            end else begin
                key_d = key_q;
                eos_d = 1'b0;
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        col_d = ~(4'b0001 << col_idx_d);
    end

    // Scan state registers; rows idle released (all ones) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
            div_cnt_q  <= {DIV_W{1'b0}};
            col_idx_q  <= 2'd0;
            col_q      <= 4'b1110;
            scan_key_q <= NO_KEY;
            key_q      <= NO_KEY;
            eos_q      <= 1'b0;
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            div_cnt_q  <= div_cnt_d;
            col_idx_q  <= col_idx_d;
            col_q      <= col_d;
            scan_key_q <= scan_key_d;
            key_q      <= key_d;
            eos_q      <= eos_d;
        end
    end

    assign col_o = col_q;
    assign key_o = key_q;
    assign eos_o = eos_q;

endmodule

// File: rtl/kypd_scan_encoder.sv
// -----------------------------------------------------------------------------
// kypd_scan_encoder
// 4x4 keypad scanner with per-press debounce; emits one ASCII code and one
// STROBE_LEN-cycle strobe per accepted press (no auto-repeat).
// Ports:
//   CLK         : system clock
//   ARST_L      : asynchronous active-low reset
//   KYPD_ROW    : keypad rows, pulled up, pressed key reads 0
//   KYPD_COL    : registered column drive, exactly one bit low
//   KBCODE      : ASCII code of the last accepted key (holds between presses)
//   kbstrobe_o  : new-key strobe, high STROBE_LEN cycles
// -----------------------------------------------------------------------------
module kypd_scan_encoder
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV       = 25000,
    parameter int DEBOUNCE_SCANS = 20,
    parameter int STROBE_LEN     = 4
) (
    input  logic       CLK,
    input  logic       ARST_L,
    input  logic [3:0] KYPD_ROW,
    output logic [3:0] KYPD_COL,
    output logic [7:0] KBCODE,
    output logic       kbstrobe_o
);

    localparam int               DEB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int               STB_W   = $clog2(STROBE_LEN + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_SCANS);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STROBE_LEN);

    logic [4:0]       scan_key_s;
    logic             scan_eos_s;
    logic             stable_s;
    logic             fire_start_s;

    logic [4:0]       cand_q,       cand_d;
    logic [DEB_W-1:0] stable_cnt_q, stable_cnt_d;
    kypd_state_e      state_q,      state_d;
    logic [STB_W-1:0] strb_cnt_q,   strb_cnt_d;
    logic [7:0]       kbcode_q,     kbcode_d;
    logic             kbstrobe_q,   kbstrobe_d;

    kypd_col_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scan (
        .clk   (CLK),
        .rst_n (ARST_L),
        .row_i (KYPD_ROW),
        .col_o (KYPD_COL),
        .key_o (scan_key_s),
        .eos_o (scan_eos_s)
    );

    // Debounce: count consecutive identical scan results (press or release).
    always_comb begin
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        if (scan_eos_s) begin
            if (scan_key_s == cand_q) begin
                if (stable_cnt_q == DEB_MAX) begin
                    stable_cnt_d = stable_cnt_q;
                end else begin
                    stable_cnt_d = stable_cnt_q + DEB_W'(1);
                end
            end else begin
                cand_d       = scan_key_s;
                stable_cnt_d = DEB_W'(1);
            end
        end else begin
            cand_d       = cand_q;
            stable_cnt_d = stable_cnt_q;
        end
    end

    // Debounce registers.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            cand_q       <= NO_KEY;
            stable_cnt_q <= {DEB_W{1'b0}};
        end else begin
            cand_q       <= cand_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign stable_s = (stable_cnt_q == DEB_MAX);

    // FSM state register, including the strobe-length counter.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            state_q    <= ARMED;
            strb_cnt_q <= {STB_W{1'b0}};
        end else begin
            state_q    <= state_d;
            strb_cnt_q <= strb_cnt_d;
        end
    end

    // FSM next state. HELD only re-arms on a stable release, so swapping
    // one held key for another never produces a second strobe.
    always_comb begin
        state_d    = state_q;
        strb_cnt_d = strb_cnt_q;
        case (state_q)
            ARMED: begin
                if ((cand_q != NO_KEY) && stable_s) begin
                    state_d    = FIRE;
                    strb_cnt_d = STB_W'(1);
                end else begin
                    state_d    = ARMED;
                    strb_cnt_d = {STB_W{1'b0}};
                end
            end
            FIRE: begin
                // strb_cnt_q counts strobe cycles already spent in FIRE.
                if (strb_cnt_q >= STB_MAX) begin
                    state_d    = HELD;
                    strb_cnt_d = {STB_W{1'b0}};
                end else begin
                    state_d    = FIRE;
                    strb_cnt_d = strb_cnt_q + STB_W'(1);
                end
            end
            HELD: begin
                if ((cand_q == NO_KEY) && stable_s) begin
                    state_d = ARMED;
                end else begin
                    state_d = HELD;
                end
                strb_cnt_d = {STB_W{1'b0}};
            end
            default: begin
                state_d    = ARMED;
                strb_cnt_d = {STB_W{1'b0}};
            end
        endcase
    end

    // FSM outputs: code latched and strobe raised on the edge entering FIRE.
    always_comb begin
        fire_start_s = (state_q == ARMED) && (state_d == FIRE);
        kbstrobe_d   = (state_d == FIRE);
        if (fire_start_s) begin
            kbcode_d = key_to_ascii(cand_q[3:0]);
        end else begin
            kbcode_d = kbcode_q;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            kbcode_q   <= 8'h00;
            kbstrobe_q <= 1'b0;
        end else begin
            kbcode_q   <= kbcode_d;
            kbstrobe_q <= kbstrobe_d;
        end
    end

    assign KBCODE     = kbcode_q;
    assign kbstrobe_o = kbstrobe_q;

endmodule
